regfile_reader: RTL

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_reader.sv
// Register-file sweep reader: walks RegLoc from First up to Last (mod 16),
// waits READ_LAT+1 edges per address for the read port, then offers each word
// on a valid/ready output and pulses Done after the last word is accepted.
module regfile_reader #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [3:0]  First,
  input  logic [3:0]  Last,
  output logic [3:0]  RegLoc,
  input  logic [15:0] RegData,
  output logic [15:0] OutData,
  output logic [3:0]  OutLoc,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned    CntW    = $clog2(READ_LAT + 2);
  localparam logic [CntW-1:0] CntLoad = CntW'(READ_LAT + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      last_q;
  logic            done_q;

  logic accept;
  logic xfer;
  logic wait_end;
  logic last_word;

  // The cycle carrying Done still belongs to the finished sweep, so a Start
  // seen alongside Done is not accepted.
  assign accept    = (state_q == StIdle) && Start && !done_q;
  assign xfer      = (state_q == StSend) && OutValid && OutReady;
  assign wait_end  = (state_q == StWait) && (cnt_q == CntOne);
  assign last_word = (OutLoc == last_q);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait:  if (wait_end) state_d = StSend;
      StSend:  if (xfer) state_d = last_word ? StIdle : StWait;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: address, wait counter, captured word and Done pulse
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RegLoc   <= 4'd0;
      last_q   <= 4'd0;
      cnt_q    <= '0;
      OutData  <= 16'd0;
      OutLoc   <= 4'd0;
      OutValid <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        RegLoc <= First;
        last_q <= Last;
        cnt_q  <= CntLoad;
      end
      if ((state_q == StWait) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CntOne;
      end
      if (wait_end) begin
        OutData  <= RegData;
        OutLoc   <= RegLoc;
        OutValid <= 1'b1;
      end
      if (xfer) begin
        OutValid <= 1'b0;
        if (last_word) begin
          done_q <= 1'b1;
        end else begin
          RegLoc <= RegLoc + 4'd1;
          cnt_q  <= CntLoad;
        end
      end
    end
  end

  // Status outputs
  always_comb begin
    Busy = (state_q != StIdle);
    Done = done_q;
  end

endmodule
